dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit and port 1 is the debug/DMA loader.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- The block latches the winning request, drives the memory's read-enable, write-enable, address, unit-size and write-data inputs for exactly one cycle, captures the read data, and returns it to the owner.
- Sits between the core/loader and the data memory; the memory's read path is combinational and its write commits on the clock edge.

Parameters:
- ADDR_W, 32, address width of requests and of mem_addr.
- DATA_W, 32, data width (word).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- m0_req  in  1  port 0 request valid.
- m0_we  in  1  port 0 store (1) / load (0).
- m0_addr  in  ADDR_W  port 0 byte address.
- m0_size  in  3  port 0 funct3 access size (byte, half, word, byte-unsigned, half-unsigned).
- m0_wdata  in  DATA_W  port 0 store data (low bits used for byte/half).
- m0_ready  out  1  port 0 request accepted this cycle.
- m0_rvalid  out  1  port 0 response pulse.
- m0_err  out  1  port 0 misaligned flag, qualified by m0_rvalid.
- m0_rdata  out  DATA_W  port 0 load data, qualified by m0_rvalid.
- m1_req, m1_we, m1_addr, m1_size, m1_wdata, m1_ready, m1_rvalid, m1_err, m1_rdata: identical set for port 1.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_size  out  3  memory unit size.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational, size-extended).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - All ready, rvalid and err outputs 0; rdata 0.
  - mem_re and mem_we 0; mem_addr, mem_size and mem_wdata 0.
  - Owner register 0; round-robin pointer (if built) 0.
- States: IDLE, ACCESS, DONE.
- Acceptance:
  - Allowed in IDLE and DONE.
  - mX_ready = (state != ACCESS) && grant==X, combinational from the mX_req inputs.
  - A handshake occurs when req && ready on a clock edge.
  - At most one port is accepted per cycle.
- Grant: fixed priority, port 0 wins when both request. Port 1 can starve; this is accepted.
- Alignment check at acceptance:
  - Half/half-unsigned with addr[0] != 0 is misaligned.
  - Word with addr[1:0] != 0 is misaligned.
  - Byte accesses are always aligned.
- Aligned accept:
  - Latch addr, size, wdata, we and owner; next state ACCESS.
  - In ACCESS, for exactly one cycle: mem_re = !we, mem_we = we, other mem_* from the latched values.
  - A store commits at the clock edge that ends ACCESS. A load captures mem_rdata into the owner's rdata at that edge.
  - Next state DONE.
- Misaligned accept:
  - No memory cycle; mem_re and mem_we stay 0.
  - Next state DONE with err = 1 and rdata = 0.
- DONE: owner's rvalid = 1 for exactly one cycle; the other port's rvalid = 0. A new request may be accepted in the same cycle.
- Next state from DONE or IDLE: ACCESS or DONE on an accept, otherwise IDLE.
- Latency:
  - Aligned: accept at edge N, mem strobes during cycle N+1, rvalid during cycle N+2.
  - Misaligned: rvalid during cycle N+1.
  - Peak throughput: one aligned access per 2 cycles.
- rdata holds its last value outside rvalid. Stores return rvalid with rdata unchanged and err = 0.
- mem_re and mem_we are never high together, and never high outside ACCESS.
- Request signals may change freely while ready = 0. The latched copy is used after acceptance.
- Reset mid-operation: the in-flight access is abandoned and mem_we drops immediately. A store in ACCESS is not committed if reset asserts before its edge. No rvalid is generated for the abandoned request.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin grant.
  - The pointer names the preferred port and flips to the other port after each accepted request.
  - When both ports request, the preferred port wins. A single requester always wins regardless of the pointer.
- Undefined: fixed port-0 priority; no pointer register exists.

Test Plan:
- Port 0 word store 0xDEADBEEF to 0x10, then word load from 0x10 → mem_we high for one cycle; m0_rvalid 2 cycles after each accept; load m0_rdata = 0xDEADBEEF, m0_err = 0.
- Both ports request word loads every cycle for 6 accepts:
  - Fixed priority → all 6 grants to port 0, m1_ready = 0 throughout.
  - With DMEM_ARB_RR_EN → grants alternate 0,1,0,1,0,1.
- Port 1 half load at 0x21, then word load at 0x22 → each: m1_rvalid 1 cycle after accept, m1_err = 1, m1_rdata = 0, mem_re/mem_we never asserted.
- Port 0 byte store 0xAB to 0x13, then byte load and byte-unsigned load from 0x13 → m0_rdata 0xFFFFFFAB and 0x000000AB; mem_size carries funct3 unchanged.
- Reset asserted during ACCESS of a store of 0x1234 to 0x40 → mem_we falls immediately, no rvalid, later load of 0x40 returns the prior contents.
- Back-to-back: port 0 request held high in DONE → new accept in DONE, mem strobes in the following cycle, no idle gap.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   port 0 : core load/store unit
//   port 1 : debug/DMA loader
//
// Each port offers a valid/ready request channel (mX_req / mX_ready) and
// receives a one-cycle response pulse (mX_rvalid) with load data and a
// misalignment flag. An accepted aligned request owns the memory for exactly
// one ACCESS cycle. The response follows in DONE, where the next request can
// already be accepted.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   mX_req/we/addr/size/wdata   request from port X (size = funct3 encoding)
//   mX_ready              request accepted on this clock edge
//   mX_rvalid/err/rdata   response pulse, misaligned flag, load data
//   mem_re/we/addr/size/wdata   memory strobes, valid only during ACCESS
//   mem_rdata             combinational, size-extended memory read data
//
// Build option
//   DMEM_ARB_RR_EN : round-robin grant between the ports. When it is
//                    undefined, port 0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_size,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_size,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic                owner_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic                sel;        // winning port when a request is present
  logic                accept;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [2:0]          req_size;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_misaligned;

  // funct3[1:0] gives the access width: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (size[1:0])
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

`ifdef DMEM_ARB_RR_EN
  logic ptr_q;

  // The pointer only matters when both ports compete. A single requester
  // always wins.
  always_comb begin
    if (m0_req && m1_req) sel = ptr_q;
    else                  sel = !m0_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr_q <= 1'b0;
    else if (accept) ptr_q <= !sel;
  end
`else
  // Port 0 has fixed priority. Port 1 only wins when port 0 is silent.
  always_comb sel = !m0_req;
`endif

  // Ready is asserted only toward a port that is actually requesting, so both
  // readies are low when nothing is pending.
  assign accept   = (state_q != ACCESS) && (m0_req || m1_req);
  assign m0_ready = accept && !sel;
  assign m1_ready = accept &&  sel;

  assign req_we         = sel ? m1_we    : m0_we;
  assign req_addr       = sel ? m1_addr  : m0_addr;
  assign req_size       = sel ? m1_size  : m0_size;
  assign req_wdata      = sel ? m1_wdata : m0_wdata;
  assign req_misaligned = misaligned(req_size, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = req_misaligned ? DONE : ACCESS;
        else        state_d = IDLE;
      end
      ACCESS:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= sel;
        we_q    <= req_we;
        err_q   <= req_misaligned;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        // A misaligned request gets no memory cycle and returns zero data.
        if (req_misaligned) begin
          if (sel) rdata1_q <= '0;
          else     rdata0_q <= '0;
        end
      end
      // Load data is captured at the edge that ends ACCESS. The memory read
      // path is combinational, so the data is valid during that cycle.
      if (state_q == ACCESS && !we_q) begin
        if (owner_q) rdata1_q <= mem_rdata;
        else         rdata0_q <= mem_rdata;
      end
    end
  end

  // The strobes decode directly from the state register. An asynchronous
  // reset during ACCESS therefore drops mem_we before the commit edge.
  assign mem_re    = (state_q == ACCESS) && !we_q;
  assign mem_we    = (state_q == ACCESS) &&  we_q;
  assign mem_addr  = addr_q;
  assign mem_size  = size_q;
  assign mem_wdata = wdata_q;

  assign m0_rvalid = (state_q == DONE) && !owner_q;
  assign m1_rvalid = (state_q == DONE) &&  owner_q;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_size, m1_size;
  logic        m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid),
    .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid),
    .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-addressed little-endian memory model with a combinational,
  // size-extended read and a write committed on the clock edge.
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma = mem_addr[9:0];

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[ma];
    b1 = mem[ma + 10'd1];
    b2 = mem[ma + 10'd2];
    b3 = mem[ma + 10'd3];
    case (mem_size)
      3'd0:    mem_rdata = {{24{b0[7]}}, b0};
      3'd1:    mem_rdata = {{16{b1[7]}}, b1, b0};
      3'd4:    mem_rdata = {24'h0, b0};
      3'd5:    mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_size[1:0] != 2'b00) mem[ma + 10'd1] <= mem_wdata[15:8];
      if (mem_size[1:0] == 2'b10) begin
        mem[ma + 10'd2] <= mem_wdata[23:16];
        mem[ma + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_size = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_size = 0; m1_wdata = 0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = 1; m0_we = we; m0_addr = addr; m0_size = size; m0_wdata = wdata;
    end else begin
      m1_req = 1; m1_we = we; m1_addr = addr; m1_size = size; m1_wdata = wdata;
    end
  endtask

  // One complete transaction on a single port. The task is entered 1 time
  // unit after a rising edge with the arbiter idle, and it leaves the arbiter
  // in the same condition.
  task automatic xfer(input string tag, input int p, input logic we,
                      input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic exp_err,
                      input logic [31:0] exp_rdata);
    set_req(p, we, addr, size, wdata);
    @(negedge clk);
    check({tag, ".ready"}, 32'(p == 0 ? m0_ready : m1_ready), 32'd1);
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    if (!exp_err) begin
      check({tag, ".mem_re"},   32'(mem_re), 32'(!we));
      check({tag, ".mem_we"},   32'(mem_we), 32'(we));
      check({tag, ".mem_addr"}, mem_addr, addr);
      check({tag, ".mem_size"}, 32'(mem_size), 32'(size));
      if (we) check({tag, ".mem_wdata"}, mem_wdata, wdata);
      check({tag, ".early_rvalid"}, 32'(p == 0 ? m0_rvalid : m1_rvalid), 32'd0);
      @(negedge clk);
    end
    check({tag, ".done_re"}, 32'(mem_re), 32'd0);
    check({tag, ".done_we"}, 32'(mem_we), 32'd0);
    check({tag, ".rvalid"}, 32'(p == 0 ? m0_rvalid : m1_rvalid), 32'd1);
    check({tag, ".other_rvalid"}, 32'(p == 0 ? m1_rvalid : m0_rvalid), 32'd0);
    check({tag, ".err"}, 32'(p == 0 ? m0_err : m1_err), 32'(exp_err));
    check({tag, ".rdata"}, p == 0 ? m0_rdata : m1_rdata, exp_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int g;
    clear_reqs();
    reset = 1;
    #1;
    check("rst.m0_ready", 32'(m0_ready), 32'd0);
    check("rst.m1_ready", 32'(m1_ready), 32'd0);
    check("rst.m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("rst.m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("rst.mem_re", 32'(mem_re), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.m0_rdata", m0_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Both ports issue word loads every cycle until six accepts.
    set_req(0, 0, 32'h100, 3'd2, 32'h0);
    set_req(1, 0, 32'h200, 3'd2, 32'h0);
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      @(negedge clk);
`ifndef DMEM_ARB_RR_EN
      check("arb.m1_ready", 32'(m1_ready), 32'd0);
`endif
      if (m0_ready || m1_ready) begin
        g = m1_ready ? 1 : 0;
`ifdef DMEM_ARB_RR_EN
        check("arb.grant", 32'(g), 32'(n % 2));
`else
        check("arb.grant", 32'(g), 32'd0);
`endif
        n++;
      end
    end
    check("arb.accepts", 32'(n), 32'd6);
    @(posedge clk); #1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;

    // Pulse reset again so that both rdata registers restart from zero.
    reset = 1;
    @(posedge clk); #1 reset = 0;

    xfer("st_word",  0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0);
    xfer("ld_word",  0, 0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    xfer("p1_ld",    1, 0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    xfer("mis_half", 1, 0, 32'h21, 3'd1, 32'h0,        1, 32'h0);
    xfer("p1_ld2",   1, 0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    xfer("mis_word", 1, 0, 32'h22, 3'd2, 32'h0,        1, 32'h0);
    xfer("st_byte",  0, 1, 32'h13, 3'd0, 32'h000000AB, 0, 32'hDEADBEEF);
    xfer("ld_byte",  0, 0, 32'h13, 3'd0, 32'h0,        0, 32'hFFFFFFAB);
    xfer("ld_ubyte", 0, 0, 32'h13, 3'd4, 32'h0,        0, 32'h000000AB);
    xfer("ld_word2", 0, 0, 32'h10, 3'd2, 32'h0,        0, 32'hABADBEEF);

    // Back-to-back: the request stays high through DONE, and the request
    // fields change while ready is low.
    set_req(0, 1, 32'h80, 3'd2, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b.ready0", 32'(m0_ready), 32'd1);
    @(posedge clk); #1;
    set_req(0, 0, 32'h80, 3'd2, 32'h11111111);
    @(negedge clk);
    check("b2b.st_we", 32'(mem_we), 32'd1);
    check("b2b.st_wdata", mem_wdata, 32'hCAFEF00D);
    check("b2b.access_ready", 32'(m0_ready), 32'd0);
    @(negedge clk);
    check("b2b.st_rvalid", 32'(m0_rvalid), 32'd1);
    check("b2b.done_ready", 32'(m0_ready), 32'd1);
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    check("b2b.ld_re", 32'(mem_re), 32'd1);
    check("b2b.ld_addr", mem_addr, 32'h80);
    check("b2b.ld_early_rvalid", 32'(m0_rvalid), 32'd0);
    @(negedge clk);
    check("b2b.ld_rvalid", 32'(m0_rvalid), 32'd1);
    check("b2b.ld_rdata", m0_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a store abandons the store.
    xfer("pre_st", 0, 1, 32'h40, 3'd2, 32'h55667788, 0, 32'hCAFEF00D);
    set_req(0, 1, 32'h40, 3'd2, 32'h00001234);
    @(posedge clk); #1;
    clear_reqs();
    #2;
    check("rsto.we_before", 32'(mem_we), 32'd1);
    reset = 1;
    #1;
    check("rsto.we_drop", 32'(mem_we), 32'd0);
    check("rsto.re_drop", 32'(mem_re), 32'd0);
    @(negedge clk);
    check("rsto.rvalid0", 32'(m0_rvalid), 32'd0);
    check("rsto.rvalid1", 32'(m1_rvalid), 32'd0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rsto.rvalid_after", 32'(m0_rvalid), 32'd0);
    @(posedge clk); #1;
    xfer("rsto.ld", 0, 0, 32'h40, 3'd2, 32'h0, 0, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
